alu64_exec_stage: RTL and testbench

Registered 64-bit execute stage for the Y86-64 pipeline. It accepts operands and a function code over a valid/ready handshake, computes the result with one of add, sub, and, or xor, and presents the result one cycle later over a valid/ready handshake. It owns the architectural condition-code register (ZF, SF, OF) and evaluates the seven Y86 branch/cmov conditions. It sits between the decode stage and the memory stage, and consumes the operand stream that the bitwise ALU units are built to answer.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu64_core.sv | 26 ++
 rtl/alu64_exec_stage.sv | 60 ++++++
 tb/tb_alu64_exec_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings, CC bit layout and condition evaluation for the Y86-64 execute stage.
package alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;
  localparam logic [2:0] C_ALWAYS = 3'd0;
  localparam logic [2:0] C_LE     = 3'd1;
  localparam logic [2:0] C_L      = 3'd2;
  localparam logic [2:0] C_E      = 3'd3;
  localparam logic [2:0] C_NE     = 3'd4;
  localparam logic [2:0] C_GE     = 3'd5;
  localparam logic [2:0] C_G      = 3'd6;
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;
  typedef enum logic {EMPTY, FULL} slot_t;
  function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] fn);
    logic zf, lt;
    zf = cc[CC_ZF];
    lt = cc[CC_SF] ^ cc[CC_OF];
    return fn == C_ALWAYS ? 1'b1 :
           fn == C_LE     ? lt | zf :
           fn == C_L      ? lt :
           fn == C_E      ? zf :
           fn == C_NE     ? !zf :
           fn == C_GE     ? !lt :
           fn == C_G      ? !lt & !zf : 1'b0;
  endfunction
endpackage

// File: rtl/alu64_core.sv
// alu64_core: combinational Y86 ALU, res = B op A, with ZF/SF/OF from the raw result.
module alu64_core import alu_pkg::*; #(
  parameter int W = 64
) (
  input  logic [1:0]   ifun_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o,
  output logic         zf_o,
  output logic         sf_o,
  output logic         of_o
);
  logic sa, sb, sr;
  always_comb begin
    res_o = ifun_i == ALU_ADD ? b_i + a_i :
            ifun_i == ALU_SUB ? b_i - a_i :
            ifun_i == ALU_AND ? b_i & a_i : b_i ^ a_i;
    sa = a_i[W-1];
    sb = b_i[W-1];
    sr = res_o[W-1];
    zf_o = res_o == '0;
    sf_o = sr;
    of_o = ifun_i == ALU_ADD ? (sa == sb) && (sr != sa) :
           ifun_i == ALU_SUB ? (sa != sb) && (sr != sb) : 1'b0;
  end
endmodule

// File: rtl/alu64_exec_stage.sv
// alu64_exec_stage: registered execute stage with CC register, condition evaluation
// and a single-slot output register that forwards downstream ready.
module alu64_exec_stage import alu_pkg::*; #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   ifun,
  input  logic [2:0]   cond_fn,
  input  logic         set_cc,
  input  logic [W-1:0] val_a,
  input  logic [W-1:0] val_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] val_e,
  output logic         cnd,
  output logic [2:0]   cc
);
  slot_t state_q, state_d;
  logic [W-1:0] val_e_q, val_e_d, res;
  logic cnd_q, cnd_d, zf, sf, of, acc;
  logic [2:0] cc_q, cc_d;
  alu64_core #(.W(W)) u_core (
    .ifun_i(ifun),
    .a_i   (val_a),
    .b_i   (val_b),
    .res_o (res),
    .zf_o  (zf),
    .sf_o  (sf),
    .of_o  (of)
  );
  assign in_ready  = state_q == EMPTY || out_ready;
  assign out_valid = state_q == FULL;
  assign acc       = in_valid && in_ready;
  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign cc        = cc_q;
  // cnd is taken from cc_q, i.e. the flags as they stood before this beat's update
  always_comb begin
    state_d = acc ? FULL : out_ready ? EMPTY : state_q;
    val_e_d = acc ? res : val_e_q;
    cnd_d   = acc ? cond_eval(cc_q, cond_fn) : cnd_q;
    cc_d    = acc && set_cc ? {zf, sf, of} : cc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      val_e_q <= '0;
      cnd_q   <= 1'b0;
      cc_q    <= CC_RESET;
    end else begin
      state_q <= state_d;
      val_e_q <= val_e_d;
      cnd_q   <= cnd_d;
      cc_q    <= cc_d;
    end
  end
endmodule

// File: tb/tb_alu64_exec_stage.sv
// tb_alu64_exec_stage: scoreboard bench; a negedge monitor predicts accepted beats
// with an arithmetic reference model and compares every consumed result.
module tb_alu64_exec_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, in_ready, set_cc, out_valid, out_ready, cnd;
  logic [1:0] ifun;
  logic [2:0] cond_fn, cc;
  logic [63:0] val_a, val_b, val_e;
  alu64_exec_stage #(.W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ifun(ifun), .cond_fn(cond_fn), .set_cc(set_cc), .val_a(val_a), .val_b(val_b),
    .out_valid(out_valid), .out_ready(out_ready), .val_e(val_e), .cnd(cnd), .cc(cc)
  );
  typedef struct packed {logic [63:0] v; logic c; logic [2:0] cc;} exp_t;
  exp_t q[$];
  logic [2:0] mcc = 3'b100;
  int errs = 0, checks = 0;
  bit rand_rdy = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] f, input logic [2:0] cf, input logic sc,
                                 input logic [63:0] a, input logic [63:0] b, input logic [2:0] c);
    exp_t e;
    logic signed [64:0] sa, sb, wide;
    logic ovf, lt, z;
    sa = {a[63], a};
    sb = {b[63], b};
    wide = 65'sd0;
    ovf = 1'b0;
    case (f)
      2'd0: begin wide = sb + sa; ovf = wide[64] != wide[63]; end
      2'd1: begin wide = sb - sa; ovf = wide[64] != wide[63]; end
      2'd2: wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
    e.v = wide[63:0];
    z = c[2];
    lt = c[1] != c[0];
    case (cf)
      3'd0: e.c = 1'b1;
      3'd1: e.c = lt || z;
      3'd2: e.c = lt;
      3'd3: e.c = z;
      3'd4: e.c = !z;
      3'd5: e.c = !lt;
      3'd6: e.c = !lt && !z;
      default: e.c = 1'b0;
    endcase
    e.cc = sc ? {e.v == 64'd0, e.v[63], ovf} : c;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_beat: got val_e=%0h expected no beat", val_e);
        end else begin
          e = q.pop_front();
          chk("sb_val_e", val_e, e.v);
          chk("sb_cnd", {63'd0, cnd}, {63'd0, e.c});
          chk("sb_cc", {61'd0, cc}, {61'd0, e.cc});
        end
      end
      if (in_valid && in_ready) begin
        e = model(ifun, cond_fn, set_cc, val_a, val_b, mcc);
        mcc = e.cc;
        q.push_back(e);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
  end
  task automatic send(input logic [1:0] f, input logic [2:0] cf, input logic sc,
                      input logic [63:0] a, input logic [63:0] b);
    ifun = f; cond_fn = cf; set_cc = sc; val_a = a; val_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errs++;
    $display("FAIL send_timeout: got in_ready=0 expected acceptance within 200 cycles");
  endtask
  task automatic idle();
    in_valid = 1'b0;
    ifun = 2'($urandom);
    cond_fn = 3'($urandom);
    set_cc = 1'($urandom);
  endtask
  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  logic [63:0] hold_v, ra, rb;
  logic [2:0] hold_cc;
  initial begin
    rst_n = 0; out_ready = 1; in_valid = 0; ifun = 0; cond_fn = 0; set_cc = 0; val_a = 0; val_b = 0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_val_e", val_e, 64'd0);
    chk("rst_cnd", {63'd0, cnd}, 64'd0);
    chk("rst_cc", {61'd0, cc}, 64'd4);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1 rst_n = 1;
    send(2'd3, 3'd3, 1, 64'd4, 64'd11);
    chk("pre_cnd", {63'd0, cnd}, 64'd1);
    chk("xor1_val_e", val_e, 64'd15);
    chk("xor1_cc", {61'd0, cc}, 64'd0);
    send(2'd3, 3'd0, 1, 64'd12, 64'd11);
    chk("xor2_val_e", val_e, 64'd7);
    send(2'd3, 3'd0, 1, 64'd9, 64'd9);
    chk("xor3_val_e", val_e, 64'd0);
    chk("xor3_cc", {61'd0, cc}, 64'd4);
    send(2'd1, 3'd0, 1, 64'd1, 64'h8000_0000_0000_0000);
    chk("subov_val_e", val_e, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("subov_cc", {61'd0, cc}, 64'd1);
    send(2'd0, 3'd2, 0, 64'd0, 64'd0);
    chk("l_cnd", {63'd0, cnd}, 64'd1);
    send(2'd0, 3'd0, 1, -64'sd13, -64'sd2);
    chk("add_val_e", val_e, -64'sd15);
    chk("add_cc", {61'd0, cc}, 64'd2);
    send(2'd2, 3'd0, 1, 64'd13, -64'sd2);
    chk("and_val_e", val_e, 64'd12);
    chk("and_cc", {61'd0, cc}, 64'd0);
    idle();
    @(posedge clk); #1;
    out_ready = 0;
    send(2'd0, 3'd0, 1, 64'd5, 64'd6);
    ifun = 2'd1; cond_fn = 3'd0; set_cc = 1; val_a = 64'd3; val_b = 64'd100; in_valid = 1;
    hold_v = val_e; hold_cc = cc;
    chk("bp_first_val_e", hold_v, 64'd11);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_val_e_hold", val_e, hold_v);
      chk("bp_cc_hold", {61'd0, cc}, {61'd0, hold_cc});
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    idle();
    chk("bp_nogap_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_new_val_e", val_e, 64'd97);
    rand_rdy = 1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end else begin
        ra = pick();
        rb = $urandom_range(0, 5) == 0 ? ra : pick();
        send(2'($urandom), 3'($urandom), 1'($urandom), ra, rb);
      end
    end
    idle();
    rand_rdy = 0;
    #2 out_ready = 1;
    for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) @(posedge clk);
    chk("drain_queue", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    out_ready = 0;
    send(2'd3, 3'd0, 1, 64'd1, 64'd2);
    idle();
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_cc", {61'd0, cc}, 64'd4);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    mcc = 3'b100;
    @(posedge clk); #1 rst_n = 1; out_ready = 1;
    send(2'd0, 3'd0, 1, 64'd3, 64'd4);
    chk("postrst_valid", {63'd0, out_valid}, 64'd1);
    chk("postrst_val_e", val_e, 64'd7);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
